// File: rtl/bcd_pkg.sv
// Shared BCD digit and seven-segment types for the BCD up/down counter.
package bcd_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  typedef logic [BCD_W-1:0] bcd_t;
  typedef logic [SEG_W-1:0] seg_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam seg_t SEG_ZERO = 7'b1000000;
  localparam seg_t SEG_OFF  = 7'b1111111;

  // Limit a raw nibble to a legal BCD digit
  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Active-low seven-segment decoder for one BCD digit (bit0=a .. bit6=g).
module seg7_decode
  import bcd_pkg::*;
(
  input  bcd_t bcd_i,
  output seg_t seg_o
);

  // Glyph lookup; non-decimal codes blank the digit
  always_comb begin
    seg_o = SEG_OFF;
    case (bcd_i)
      4'd0:    seg_o = SEG_ZERO;
      4'd1:    seg_o = 7'b1111001;
      4'd2:    seg_o = 7'b0100100;
      4'd3:    seg_o = 7'b0110000;
      4'd4:    seg_o = 7'b0011001;
      4'd5:    seg_o = 7'b0010010;
      4'd6:    seg_o = 7'b0000010;
      4'd7:    seg_o = 7'b1111000;
      4'd8:    seg_o = 7'b0000000;
      4'd9:    seg_o = 7'b0010000;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter advanced by a synchronised pushbutton,
// with parallel load, terminal count, wrap pulse and seven-segment outputs.
// Build option: define BCD_COUNTER_SAT_EN to saturate instead of wrapping.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    En,
  input  logic                    Up,
  input  logic                    Step,
  input  logic                    Load,
  input  logic [BCD_W*DIGITS-1:0] LoadVal,
  output logic [BCD_W*DIGITS-1:0] Q,
  output logic [SEG_W*DIGITS-1:0] Hex,
  output logic                    TC,
  output logic                    Wrap
);

`ifdef BCD_COUNTER_SAT_EN
  localparam bit SatEn = 1'b1;
`else
  localparam bit SatEn = 1'b0;
`endif

  logic                   s1_q, s2_q, s3_q;
  bcd_t [DIGITS-1:0]      cnt_q, cnt_d;
  logic                   wrap_q, wrap_d;
  logic                   all_nine, all_zero;
  logic                   count_en;
  logic                   carry;

  // Terminal-count detection over all digits
  always_comb begin
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (cnt_q[i] != BCD_MAX) all_nine = 1'b0;
      if (cnt_q[i] != '0)      all_zero = 1'b0;
    end
  end

  assign TC       = Up ? all_nine : all_zero;
  // One count per Step rising edge, dropped when disabled
  assign count_en = s2_q & ~s3_q & En;

  // Next count: load has priority, then a ripple-carry BCD step
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    carry  = 1'b1;
    if (Load) begin
      for (int i = 0; i < DIGITS; i++) begin
        cnt_d[i] = bcd_clamp(LoadVal[i*BCD_W +: BCD_W]);
      end
    end else if (count_en) begin
      wrap_d = TC;
      if (!(SatEn && TC)) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (carry) begin
            if (Up) begin
              if (cnt_q[i] == BCD_MAX) begin
                cnt_d[i] = '0;
              end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
                carry    = 1'b0;
              end
            end else begin
              if (cnt_q[i] == '0) begin
                cnt_d[i] = BCD_MAX;
              end else begin
                cnt_d[i] = cnt_q[i] - 4'd1;
                carry    = 1'b0;
              end
            end
          end
        end
      end
    end
  end

  // Step synchroniser, count and wrap registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      s1_q   <= Step;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign Q    = cnt_q;
  assign Wrap = wrap_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    seg7_decode u_seg (
      .bcd_i (cnt_q[g]),
      .seg_o (Hex[g*SEG_W +: SEG_W])
    );
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter (DIGITS=4) with an integer-valued
// reference model and an event-based view of Step edge timing.
module tb_bcd_updown_counter;

  localparam int unsigned ND   = 4;
  localparam int unsigned MAXV = 9999;

  logic            Clock = 1'b0;
  logic            Reset, En, Up, Step, Load;
  logic [4*ND-1:0] LoadVal;
  logic [4*ND-1:0] Q;
  logic [7*ND-1:0] Hex;
  logic            TC, Wrap;

  bcd_updown_counter #(.DIGITS(ND)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .En      (En),
    .Up      (Up),
    .Step    (Step),
    .Load    (Load),
    .LoadVal (LoadVal),
    .Q       (Q),
    .Hex     (Hex),
    .TC      (TC),
    .Wrap    (Wrap)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int unsigned val;
    logic        wrap;
  } exp_t;

  exp_t        sb[$];
  int          pend[$];
  int          edge_n   = 0;
  bit          prev_low = 1'b1;
  int unsigned m_val    = 0;
  logic        m_wrap   = 1'b0;
  bit          done     = 1'b0;
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [15:0] to_bcd(input int unsigned v);
    logic [15:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < ND; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int unsigned load_val(input logic [15:0] lv);
    int unsigned v, mul, d;
    v = 0;
    mul = 1;
    for (int i = 0; i < ND; i++) begin
      d = 32'(lv[i*4 +: 4]);
      if (d > 9) d = 9;
      v = v + d * mul;
      mul = mul * 10;
    end
    return v;
  endfunction

  function automatic logic [6:0] glyph(input int unsigned d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] hex_of(input int unsigned v);
    logic [27:0] h;
    int unsigned t;
    t = v;
    for (int i = 0; i < ND; i++) begin
      h[i*7 +: 7] = glyph(t % 10);
      t = t / 10;
    end
    return h;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model for one rising edge, using the inputs driven for it
  task automatic model_edge();
    bit apply, tc;
    edge_n++;
    if (Reset) begin
      m_val = 0;
      m_wrap = 1'b0;
      pend.delete();
      prev_low = 1'b1;
    end else begin
      apply = 1'b0;
      if (pend.size() > 0 && pend[0] == edge_n) begin
        void'(pend.pop_front());
        apply = En;
      end
      if (Step && prev_low) pend.push_back(edge_n + 2);
      prev_low = !Step;
      m_wrap = 1'b0;
      if (Load) begin
        m_val = load_val(LoadVal);
      end else if (apply) begin
        tc = Up ? (m_val == MAXV) : (m_val == 0);
        m_wrap = tc;
`ifdef BCD_COUNTER_SAT_EN
        if (!tc) m_val = Up ? m_val + 1 : m_val - 1;
`else
        if (Up) m_val = tc ? 0 : m_val + 1;
        else    m_val = tc ? MAXV : m_val - 1;
`endif
      end
    end
    sb.push_back('{val: m_val, wrap: m_wrap});
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
  endtask

  task automatic pulse(output logic wrap_seen);
    Step = 1'b1;
    tick();
    tick();
    Step = 1'b0;
    tick();
    wrap_seen = Wrap;
    tick();
    tick();
  endtask

  // Monitor: compare every post-edge output against the scoreboard
  initial begin : monitor
    exp_t e;
    logic [15:0] qe;
    forever begin
      @(posedge Clock);
      #4;
      if (sb.size() == 0) begin
        if (done) break;
        continue;
      end
      e  = sb.pop_front();
      qe = to_bcd(e.val);
      chk("mon_q",    64'(Q),    64'(qe));
      chk("mon_wrap", 64'(Wrap), 64'(e.wrap));
      chk("mon_tc",   64'(TC),   64'(Up ? (e.val == MAXV) : (e.val == 0)));
      chk("mon_hex",  64'(Hex),  64'(hex_of(e.val)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  // Driver: directed scenarios followed by random traffic
  initial begin : driver
    logic ws;
    Reset = 1'b1; Load = 1'b0; En = 1'b1; Up = 1'b1; Step = 1'b0; LoadVal = '0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    chk("reset_q",   64'(Q),   64'h0);
    chk("reset_hex", 64'(Hex), 64'({4{7'b1000000}}));
    chk("reset_tc_up", 64'(TC), 64'h0);
    Up = 1'b0;
    #1 chk("reset_tc_down", 64'(TC), 64'h1);
    Up = 1'b1;

    repeat (10) pulse(ws);
    chk("ten_steps_q", 64'(Q), 64'h0010);
    chk("ten_steps_hex0", 64'(Hex[6:0]), 64'(7'b1000000));
    chk("ten_steps_hex1", 64'(Hex[13:7]), 64'(7'b1111001));

    Load = 1'b1; LoadVal = 16'h9999;
    tick();
    Load = 1'b0;
    chk("load9999_tc", 64'(TC), 64'h1);
    pulse(ws);
`ifdef BCD_COUNTER_SAT_EN
    chk("up_top_q", 64'(Q), 64'h9999);
`else
    chk("up_top_q", 64'(Q), 64'h0000);
`endif
    chk("up_top_wrap_pulse", 64'(ws), 64'h1);
    chk("up_top_wrap_clear", 64'(Wrap), 64'h0);

    Load = 1'b1; LoadVal = 16'h0100; Up = 1'b0;
    tick();
    Load = 1'b0;
    pulse(ws);
    chk("down_borrow_q", 64'(Q), 64'h0099);
    chk("down_borrow_tc", 64'(TC), 64'h0);
    chk("down_borrow_nowrap", 64'(ws), 64'h0);
    Load = 1'b1; LoadVal = 16'h0000;
    tick();
    Load = 1'b0;
    chk("load0_tc_down", 64'(TC), 64'h1);
    pulse(ws);
`ifdef BCD_COUNTER_SAT_EN
    chk("down_bottom_q", 64'(Q), 64'h0000);
`else
    chk("down_bottom_q", 64'(Q), 64'h9999);
`endif
    chk("down_bottom_wrap", 64'(ws), 64'h1);

    Up = 1'b1; Load = 1'b1; LoadVal = 16'h0042;
    tick();
    Load = 1'b0;
    Step = 1'b1;
    repeat (50) tick();
    Step = 1'b0;
    repeat (3) tick();
    chk("held_step_q", 64'(Q), 64'h0043);
    En = 1'b0;
    pulse(ws);
    En = 1'b1;
    tick();
    tick();
    chk("en_low_q", 64'(Q), 64'h0043);

    Step = 1'b1;
    tick();
    tick();
    Step = 1'b0; Load = 1'b1; LoadVal = 16'h12F4;
    tick();
    Load = 1'b0;
    chk("load_vs_count_q", 64'(Q), 64'h1294);
    tick();
    tick();
    chk("load_vs_count_after", 64'(Q), 64'h1294);

    Step = 1'b1;
    tick();
    Reset = 1'b1; Step = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    repeat (5) tick();
    chk("reset_midcount_q", 64'(Q), 64'h0000);

    Step = 1'b1; Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    repeat (10) tick();
    Step = 1'b0;
    tick();
    chk("step_through_reset_q", 64'(Q), 64'h0001);

    for (int k = 0; k < 500; k++) begin
      Reset = ($urandom_range(0, 63) == 0);
      Load  = ($urandom_range(0, 15) == 0);
      En    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) Up = ~Up;
      if ($urandom_range(0, 2) == 0) Step = ~Step;
      case ($urandom_range(0, 4))
        0:       LoadVal = 16'($urandom);
        1:       LoadVal = 16'h9999;
        2:       LoadVal = 16'h0000;
        3:       LoadVal = 16'h9998;
        default: LoadVal = 16'h0001;
      endcase
      tick();
    end
    Reset = 1'b0; Load = 1'b0; Step = 1'b0;
    repeat (4) tick();
    done = 1'b1;
  end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of BCD digits, legal range 1..8.
REQ-002 SHALL have port Clock  input  1  meaning the single system clock; all flops are rising-edge.
REQ-003 SHALL have port Reset  input  1  meaning synchronous, active-high reset.
REQ-004 SHALL have port En  input  1  meaning count enable.
REQ-005 SHALL have port Up  input  1  meaning count direction: 1=up, 0=down.
REQ-006 SHALL have port Step  input  1  meaning an asynchronous pushbutton-level count request.
REQ-007 SHALL have port Load  input  1  meaning synchronous parallel load.
REQ-008 SHALL have port LoadVal  input  4*DIGITS  meaning the BCD load value, with digit 0 in bits [3:0].
REQ-009 SHALL have port Q  output  4*DIGITS  meaning the registered BCD count.
REQ-010 SHALL have port Hex  output  7*DIGITS  meaning active-low seven-segment codes, 7 bits per digit, bit0=a through bit6=g.
REQ-011 SHALL have port TC  output  1  meaning terminal count (combinational).
REQ-012 SHALL have port Wrap  output  1  meaning a registered one-cycle pulse on a wrap or saturation event.

Function
REQ-013 SHALL pass Step through two synchroniser flops (s1, s2) and one history flop (s3), with the count pulse defined as s2 & ~s3.
REQ-014 SHALL update Q on the 3rd rising Clock edge after Step rises, counting the first edge that samples Step high as edge 1.
REQ-015 SHALL change Q by exactly one count per Step rising edge, however long Step is held high.
REQ-016 SHALL apply a count only on cycles where the count pulse and En are both 1; if En=0, the pulse is discarded, not queued.
REQ-017 SHALL use the priority Reset > Load > count within any single cycle.
REQ-018 SHALL, when Load=1, set Q to LoadVal on the next edge, clamping any digit greater than 9 to 9 and ignoring a coincident count pulse.
REQ-019 SHALL, on an up count, increment digit i only when all lower digits are 9; a digit at 9 that increments goes to 0.
REQ-020 SHALL, on a down count, decrement digit i only when all lower digits are 0; a digit at 0 that decrements goes to 9.
REQ-021 SHALL never hold a digit value above 9 in Q.
REQ-022 SHALL drive TC=1 when Up=1 and all digits are 9, or when Up=0 and all digits are 0, and TC=0 otherwise.
REQ-023 SHALL drive Wrap=1 for exactly one cycle, on the edge after a count is applied while TC=1, and Wrap=0 otherwise.
REQ-024 SHALL decode Hex combinationally from Q, one digit per 7-bit field.
REQ-025 SHALL let Up change on any cycle, with the new value taking effect on the next applied count.

Reset
REQ-026 SHALL, on Reset=1 at a rising edge, clear Q to 0, Wrap to 0, and s1, s2 and s3 to 0.
REQ-027 SHALL, after reset, drive Hex to the "0" glyph (7'b1000000) on every digit, and drive TC to Up-dependent per REQ-022.
REQ-028 SHALL, when Reset asserts mid-count, discard any in-flight Step pulse.
REQ-029 SHALL, when Step is held high through reset release, produce exactly one count after release; this is documented behaviour.

Configuration
REQ-030 SHALL provide macro BCD_COUNTER_SAT_EN.
REQ-031 SHALL, when BCD_COUNTER_SAT_EN is defined, leave Q unchanged for a count applied while TC=1 (saturate at all-9s up, all-0s down), and still pulse Wrap.
REQ-032 SHALL, when BCD_COUNTER_SAT_EN is undefined, wrap all-9s to all-0s when counting up and all-0s to all-9s when counting down.

Structure
REQ-033 SHALL place in shared package bcd_pkg: typedef bcd_t (4-bit digit), constant BCD_MAX=9, typedef seg_t (7-bit), and constant SEG_ZERO=7'b1000000.
REQ-034 SHALL instantiate sub-module seg7_decode (one bcd_t in, one seg_t out) DIGITS times through a generate loop.
REQ-035 SHALL have seg7_decode drive all segments off (7'b1111111) for input codes 10..15.

Verification
REQ-036 SHALL cover: DIGITS=4, reset, Up=1, En=1, 10 Step pulses -> Q=16'h0010, Hex0=7'b1000000, Hex1=7'b1111001.
REQ-037 SHALL cover: Load LoadVal=16'h9999, Up=1, one Step -> Q=16'h0000 and Wrap high for one cycle (without SAT_EN); Q=16'h9999 and Wrap pulse (with SAT_EN).
REQ-038 SHALL cover: Q=16'h0100, Up=0, one Step -> Q=16'h0099, TC=0; then Load 16'h0000 -> TC=1.
REQ-039 SHALL cover: Step held high 50 cycles -> exactly one increment; En=0 during a Step edge -> Q unchanged.
REQ-040 SHALL cover: Load=1 and count pulse in the same cycle with LoadVal=16'h12F4 -> Q=16'h1294.
REQ-041 SHALL cover: Reset asserted one cycle after Step rises -> Q=0 and no count after reset release.
